// File: rtl/airi5c_regfile_mp.sv
// Multi-port integer register file with dual write ports, pending-write scoreboard and debug access.
// Optional REGFILE_BYPASS_EN macro enables same-cycle write-to-read forwarding.
module airi5c_regfile_mp #(
  parameter int          XLEN       = 32,
  parameter int          NREGS      = 32,
  parameter int          NRD        = 3,
  parameter int          AW         = $clog2(NREGS),
  parameter logic [31:0] RESET_BASE = 32'hdeadbe00
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NRD*AW-1:0]    ra_i,
  output logic [NRD*XLEN-1:0]  rd_o,
  input  logic                 wa_en_i,
  input  logic [AW-1:0]        wa_addr_i,
  input  logic [XLEN-1:0]      wa_data_i,
  input  logic [XLEN-1:0]      wa_data_hi_i,
  input  logic                 wa_pair_i,
  input  logic                 wb_en_i,
  input  logic [AW-1:0]        wb_addr_i,
  input  logic [XLEN-1:0]      wb_data_i,
  input  logic                 sb_set_i,
  input  logic [AW-1:0]        sb_addr_i,
  output logic [NREGS-1:0]     busy_o,
  output logic                 collision_o,
  input  logic                 dm_req_i,
  input  logic                 dm_we_i,
  input  logic [AW-1:0]        dm_addr_i,
  input  logic [XLEN-1:0]      dm_wd_i,
  output logic                 dm_ack_o,
  output logic [XLEN-1:0]      dm_rd_o
);

  typedef enum logic {IDLE, ACK} dm_state_t;

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] a_we, b_we, d_we, sb_mask;
  logic [XLEN-1:0]  a_wd [NREGS];
  logic [NREGS-1:0] busy_reg;
  logic             collision_reg;
  logic [XLEN-1:0]  dm_rd_reg;
  dm_state_t        state_reg, state_next;
  logic             grant;

  // Per-register write/set strobes; x0 never takes any of them.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_dec
    localparam logic [AW-1:0] IDX = AW'(gi);
    if (gi == 0) begin : g_x0
      assign a_we[gi]    = 1'b0;
      assign a_wd[gi]    = '0;
      assign b_we[gi]    = 1'b0;
      assign d_we[gi]    = 1'b0;
      assign sb_mask[gi] = 1'b0;
    end else begin : g_xn
      assign a_we[gi]    = wa_en_i && (wa_pair_i ? (wa_addr_i[AW-1:1] == IDX[AW-1:1])
                                                 : (wa_addr_i == IDX));
      assign a_wd[gi]    = (wa_pair_i && IDX[0]) ? wa_data_hi_i : wa_data_i;
      assign b_we[gi]    = wb_en_i && (wb_addr_i == IDX);
      assign d_we[gi]    = grant && dm_we_i && (dm_addr_i == IDX);
      assign sb_mask[gi] = sb_set_i && (sb_addr_i == IDX);
    end
  end

  // Port A wins over port B; debug is only granted when both are idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= (i == 0) ? '0 : XLEN'(RESET_BASE + 32'(i));
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (a_we[i])      regs[i] <= a_wd[i];
        else if (b_we[i]) regs[i] <= wb_data_i;
        else if (d_we[i]) regs[i] <= dm_wd_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_reg      <= '0;
      collision_reg <= 1'b0;
      dm_rd_reg     <= '0;
      state_reg     <= IDLE;
    end else begin
      busy_reg      <= (busy_reg & ~b_we) | sb_mask;
      collision_reg <= |(a_we & b_we);
      if (grant && !dm_we_i)
        dm_rd_reg <= regs[dm_addr_i];
      state_reg     <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dm_req_i && !wa_en_i && !wb_en_i) begin
          grant      = 1'b1;
          state_next = ACK;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   raddr;
    logic [XLEN-1:0] rdata;
    assign raddr = ra_i[gi*AW +: AW];
    always_comb begin
      rdata = (raddr == '0) ? '0 : regs[raddr];
`ifdef REGFILE_BYPASS_EN
      if (raddr != '0) begin
        if (a_we[raddr])      rdata = a_wd[raddr];
        else if (b_we[raddr]) rdata = wb_data_i;
        else if (d_we[raddr]) rdata = dm_wd_i;
      end
`endif
    end
    assign rd_o[gi*XLEN +: XLEN] = rdata;
  end

  assign busy_o      = busy_reg;
  assign collision_o = collision_reg;
  assign dm_ack_o    = (state_reg == ACK);
  assign dm_rd_o     = dm_rd_reg;

endmodule

// File: tb/tb_airi5c_regfile_mp.sv
// Randomised and directed bench for airi5c_regfile_mp against an array-level reference model.
module tb_airi5c_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] ra = '0;
  logic [95:0] rd;
  logic        wa_en = 0, wa_pair = 0, wb_en = 0, sb_set = 0;
  logic [4:0]  wa_addr = 0, wb_addr = 0, sb_addr = 0, dm_addr = 0;
  logic [31:0] wa_data = 0, wa_data_hi = 0, wb_data = 0, dm_wd = 0;
  logic [31:0] busy;
  logic        collision, dm_req = 0, dm_we = 0, dm_ack;
  logic [31:0] dm_rd;

  int checks = 0;
  int errors = 0;

  airi5c_regfile_mp dut (
    .clk_i(clk), .rst_ni(rst_n), .ra_i(ra), .rd_o(rd),
    .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data), .wa_data_hi_i(wa_data_hi),
    .wa_pair_i(wa_pair), .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .sb_set_i(sb_set), .sb_addr_i(sb_addr), .busy_o(busy), .collision_o(collision),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wd_i(dm_wd),
    .dm_ack_o(dm_ack), .dm_rd_o(dm_rd)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_regs [32];
  logic [31:0] m_busy, m_dmrd;
  logic        m_coll, m_ack;

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) m_regs[r] = (r == 0) ? 32'h0 : 32'hdeadbe00 + r;
    m_busy = 0; m_dmrd = 0; m_coll = 0; m_ack = 0;
  endfunction

  function automatic logic [31:0] a_mask();
    logic [31:0] m;
    int base;
    if (!wa_en) return 32'h0;
    base = int'(wa_addr) & 30;
    m = wa_pair ? ((32'(1) << base) | (32'(1) << (base + 1))) : (32'(1) << wa_addr);
    return m & ~32'h1;
  endfunction

  function automatic logic [31:0] a_val(int r);
    return (wa_pair && r[0]) ? wa_data_hi : wa_data;
  endfunction

  function automatic logic [31:0] b_mask();
    return wb_en ? ((32'(1) << wb_addr) & ~32'h1) : 32'h0;
  endfunction

  function automatic logic granted();
    return !m_ack && dm_req && !wa_en && !wb_en;
  endfunction

  function automatic logic [31:0] d_mask();
    return (granted() && dm_we) ? ((32'(1) << dm_addr) & ~32'h1) : 32'h0;
  endfunction

  function automatic logic [31:0] m_read(int r);
    logic [31:0] am, bm, dmk;
    am = a_mask(); bm = b_mask(); dmk = d_mask();
    if (r == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (am[r])  return a_val(r);
    if (bm[r])  return wb_data;
    if (dmk[r]) return dm_wd;
`endif
    return m_regs[r];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      logic [31:0] am, bm, dmk;
      logic g;
      am = a_mask(); bm = b_mask(); dmk = d_mask(); g = granted();
      if (g && !dm_we) m_dmrd = m_regs[dm_addr];
      for (int r = 1; r < 32; r++) begin
        if (am[r])       m_regs[r] = a_val(r);
        else if (bm[r])  m_regs[r] = wb_data;
        else if (dmk[r]) m_regs[r] = dm_wd;
      end
      m_coll = |(am & bm);
      m_busy = m_busy & ~bm;
      if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
      m_ack = g;
    end
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++)
      chk($sformatf("rd_port%0d(x%0d)", k, ra[k*5 +: 5]), rd[k*32 +: 32], m_read(int'(ra[k*5 +: 5])));
    chk("busy", busy, m_busy);
    chk("collision", {31'b0, collision}, {31'b0, m_coll});
    chk("dm_ack", {31'b0, dm_ack}, {31'b0, m_ack});
    chk("dm_rd", dm_rd, m_dmrd);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    wa_en = 0; wa_pair = 0; wb_en = 0; sb_set = 0;
  endtask

  task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    ra = {a2, a1, a0};
  endtask

  task automatic dbg(input logic we, input logic [4:0] addr, input logic [31:0] wd, output logic ok);
    step();
    dm_req = 1; dm_we = we; dm_addr = addr; dm_wd = wd;
    ok = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (dm_ack) begin ok = 1; dm_req = 0; break; end
      @(posedge clk); #1;
    end
    dm_req = 0;
  endtask

  initial begin
    int cnt;
    int ack_cycle;
    logic ok;
    logic last_ack;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    set_ra(5'd0, 5'd5, 5'd31);
    @(negedge clk);
    chk("reset_x0", rd[31:0], 32'h0);
    chk("reset_x5", rd[63:32], 32'hdeadbe05);
    chk("reset_x31", rd[95:64], 32'hdeadbe1f);
    chk("reset_busy", busy, 32'h0);
    chk("reset_ack", {31'b0, dm_ack}, 32'h0);

    // Pair write with odd address, then pair at x0/x1
    step(); wa_en = 1; wa_pair = 1; wa_addr = 7; wa_data = 32'h11111111; wa_data_hi = 32'h22222222;
    step(); idle(); set_ra(5'd6, 5'd7, 5'd0);
    @(negedge clk);
    chk("pair_x6", rd[31:0], 32'h11111111);
    chk("pair_x7", rd[63:32], 32'h22222222);
    step(); wa_en = 1; wa_pair = 1; wa_addr = 1; wa_data = 32'h33333333; wa_data_hi = 32'h22222222;
    step(); idle(); set_ra(5'd1, 5'd0, 5'd0);
    @(negedge clk);
    chk("pair_x1", rd[31:0], 32'h22222222);
    chk("pair_x0", rd[63:32], 32'h0);

    // Scoreboard set then clear two cycles later
    step(); sb_set = 1; sb_addr = 9;
    cnt = 0;
    set_ra(5'd9, 5'd0, 5'd0);
    for (int c = 1; c <= 4; c++) begin
      step(); sb_set = 0; wb_en = (c == 2); wb_addr = 9; wb_data = 32'hcafef00d;
      @(negedge clk);
      if (busy[9]) cnt++;
    end
    chk("busy9_cycles", cnt, 2);
    chk("x9_after_wb", rd[31:0], 32'hcafef00d);
    step(); sb_set = 1; sb_addr = 9; wb_en = 1; wb_addr = 9; wb_data = 32'h12345678;
    step(); idle();
    @(negedge clk);
    chk("set_wins", {31'b0, busy[9]}, 32'h1);
    step(); wb_en = 1; wb_addr = 9; wb_data = 32'h0;
    step(); idle();

    // A/B collision
    step(); wa_en = 1; wa_addr = 4; wa_data = 32'hA; wb_en = 1; wb_addr = 4; wb_data = 32'hB;
    step(); idle(); set_ra(5'd4, 5'd0, 5'd0);
    @(negedge clk);
    chk("coll_pulse", {31'b0, collision}, 32'h1);
    chk("coll_x4", rd[31:0], 32'hA);
    step();
    @(negedge clk);
    chk("coll_clear", {31'b0, collision}, 32'h0);

    // Debug read blocked by port A for three cycles
    step(); dm_req = 1; dm_we = 0; dm_addr = 3; wa_en = 1; wa_addr = 20; wa_data = 32'h01020304;
    ack_cycle = 0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) begin step(); wa_en = (c <= 3); end
      @(negedge clk);
      if (dm_ack && ack_cycle == 0) begin ack_cycle = c; dm_req = 0; end
    end
    dm_req = 0;
    chk("dm_ack_cycle", ack_cycle, 5);
    chk("dm_rd_x3", dm_rd, 32'hdeadbe03);

    // Debug writes to x0 and x10, readback of x10
    dbg(1'b1, 5'd0, 32'hffffffff, ok);
    chk("dm_wr_x0_ack", {31'b0, ok}, 32'h1);
    dbg(1'b1, 5'd10, 32'h0badc0de, ok);
    chk("dm_wr_x10_ack", {31'b0, ok}, 32'h1);
    dbg(1'b0, 5'd10, 32'h0, ok);
    chk("dm_rd_x10_ack", {31'b0, ok}, 32'h1);
    chk("dm_rd_x10", dm_rd, 32'h0badc0de);
    step(); set_ra(5'd0, 5'd10, 5'd0);
    @(negedge clk);
    chk("x0_after_dm", rd[31:0], 32'h0);
    chk("x10_after_dm", rd[63:32], 32'h0badc0de);

    // Same-cycle read of a register being written
    step(); wa_en = 1; wa_addr = 12; wa_data = 32'h5a5a5a5a; set_ra(5'd12, 5'd0, 5'd0);
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("bypass_same", rd[31:0], 32'h5a5a5a5a);
`else
    chk("bypass_same", rd[31:0], 32'hdeadbe0c);
`endif
    step(); idle();
    @(negedge clk);
    chk("bypass_next", rd[31:0], 32'h5a5a5a5a);

    // Randomised traffic
    last_ack = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); last_ack = dm_ack;
      @(posedge clk); #1;
      wa_en = ($urandom % 3) == 0;  wa_pair = $urandom % 2;
      wa_addr = 5'($urandom); wa_data = $urandom; wa_data_hi = $urandom;
      wb_en = ($urandom % 3) == 0;  wb_addr = 5'($urandom); wb_data = $urandom;
      sb_set = ($urandom % 4) == 0; sb_addr = 5'($urandom);
      ra = 15'($urandom);
      if (dm_req && last_ack) dm_req = 0;
      else if (!dm_req && ($urandom % 4) == 0) begin
        dm_req = 1; dm_we = $urandom % 2; dm_addr = 5'($urandom); dm_wd = $urandom;
      end
    end
    step(); idle(); dm_req = 0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/airi5c_regfile_mp.md
Name: airi5c_regfile_mp

Overview:
Parametrised multi-port integer register file for the next AIRI5C pipeline generation.
- Configurable width, register count and number of read ports.
- Two write ports: single-cycle ALU path A with 64-bit pair writes, and long-latency mul/div/load path B.
- Per-register pending-write scoreboard; request/acknowledge debug-module access port.
- Sits between decode/issue (reads, scoreboard set) and writeback.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, register count incl. x0 (16 for E-extension builds); power of two
NRD, 3, number of read ports
AW, $clog2(NREGS), register address width (derived, not overridden)
RESET_BASE, 32'hdeadbe00, register i resets to RESET_BASE + i

Ports:
clk_i  in  1  core clock
rst_ni  in  1  asynchronous active-low reset
ra_i  in  NRD*AW  read addresses; port k = bits [k*AW +: AW]
rd_o  out  NRD*XLEN  read data; port k = bits [k*XLEN +: XLEN]
wa_en_i  in  1  port A write enable
wa_addr_i  in  AW  port A address
wa_data_i  in  XLEN  port A data (even register of a pair)
wa_data_hi_i  in  XLEN  port A data for the odd register of a pair
wa_pair_i  in  1  port A 64-bit pair write
wb_en_i  in  1  port B write enable; also clears the busy bit
wb_addr_i  in  AW  port B address
wb_data_i  in  XLEN  port B data
sb_set_i  in  1  mark register pending (long-latency issue)
sb_addr_i  in  AW  register to mark
busy_o  out  NREGS  pending-write mask; bit 0 is always 0
collision_o  out  1  registered one-cycle pulse: A and B wrote the same register in the same cycle
dm_req_i  in  1  debug access request, level, held until ack
dm_we_i  in  1  debug write (1) / read (0)
dm_addr_i  in  AW  debug register address
dm_wd_i  in  XLEN  debug write data
dm_ack_o  out  1  one-cycle acknowledge
dm_rd_o  out  XLEN  registered debug read data

Behaviour:
- Reset (async, rst_ni low):
  - Register i (1..NREGS-1) = RESET_BASE + i, truncated to XLEN.
  - busy_o = 0, collision_o = 0, dm_ack_o = 0, dm_rd_o = 0.
  - Any in-flight debug request is dropped; the master must re-request.
- x0: reads always return 0. Writes to address 0 from any source are discarded; sb_set on x0 is ignored.
- Reads: combinational. rd_o[k] = reg[ra_i[k]].
- Port A, single write: reg[wa_addr_i] <= wa_data_i at the clock edge.
- Port A, pair write (wa_pair_i = 1):
  - reg[{addr[AW-1:1],0}] <= wa_data_i and reg[{addr[AW-1:1],1}] <= wa_data_hi_i.
  - addr[0] is ignored. A pair at x0/x1 writes x1 only.
- Port B: reg[wb_addr_i] <= wb_data_i.
- A and B target the same register (pair halves included):
  - Port A data is stored.
  - collision_o pulses high in the next cycle.
- Scoreboard:
  - sb_set_i sets busy[sb_addr_i] at the next edge.
  - wb_en_i clears busy[wb_addr_i].
  - Set and clear on the same register in the same cycle: set wins.
  - Port A writes do not touch busy.
- Debug handshake, state machine IDLE -> ACK -> IDLE:
  - IDLE: dm_req_i = 1 is granted only in a cycle with wa_en_i = 0 and wb_en_i = 0. Otherwise it waits; there is no timeout.
  - On grant: a write updates the register (x0 discarded; busy unaffected); a read latches reg[dm_addr_i] into dm_rd_o. FSM moves to ACK.
  - ACK: dm_ack_o = 1 for exactly one cycle, then IDLE.
  - A request still high in the cycle after ACK is treated as a new request.
  - dm_rd_o holds its value until the next debug read.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-to-read forwarding. If ra_i[k] matches a register being written this cycle (port A incl. pair halves, port B, or a granted debug write), rd_o[k] returns that write data. Priority: port A > port B > debug. x0 never bypassed.
- Undefined: rd_o shows stored contents only; new data becomes visible the cycle after the write.

Test Plan:
- Release reset, read x0..x31 -> x0 = 0, x5 = 32'hdeadbe05, x31 = 32'hdeadbe1f; busy_o = 0; dm_ack_o = 0.
- Port A pair write addr = 7 (odd), data = 32'h11111111 / hi = 32'h22222222 -> x6 = 32'h11111111, x7 = 32'h22222222; pair at addr 1 writes only x1 = 32'h22222222.
- sb_set x9, then wb_en x9 with 32'hcafef00d two cycles later -> busy_o[9] high for exactly 2 cycles, x9 = 32'hcafef00d; simultaneous sb_set x9 and wb_en x9 -> busy_o[9] stays 1.
- A and B both write x4 (32'hA, 32'hB) in the same cycle -> x4 = 32'hA; collision_o = 1 for one cycle.
- dm_req_i read of x3 while wa_en_i is high for 3 cycles -> dm_ack_o rises in the 5th cycle after request start (grant in cycle 4, ack in cycle 5); dm_rd_o = current x3; debug write to x0 -> ack given, x0 still reads 0.
- With REGFILE_BYPASS_EN: write x12 = 32'h5a5a5a5a while ra_i port 0 = 12 -> rd_o port 0 = 32'h5a5a5a5a in the same cycle. Without it: old value that cycle, new value the next.
